// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters and the shared alu_arbiter.
// The slave side is the arbiter; the master side drives requests and consumes responses.
interface alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [2:0]       req0_f;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [2:0]       req1_f;
    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_ready;
    logic [31:0]      rsp_y;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_f,
        input  req1_valid, req1_a, req1_b, req1_f,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_overflow,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_f,
        output req1_valid, req1_a, req1_b, req1_f,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_overflow,
        input  grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single-cycle ALU.
// One operation in flight: IDLE grants, EXEC computes, RESP holds until consumed.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_f;
    logic             r_gid;
    logic             r_rsp_id;
    logic [31:0]      r_y;
    logic             r_zero;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_g0;
    logic             w_g1;
    logic             w_idle;
    logic             w_acc;
    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_rsp_valid;
    logic [31:0]      w_bb;
    logic [31:0]      w_sum;
    logic [31:0]      w_y;
    logic             w_ovf;

    // r_last records the previous winner; on a tie the other one wins
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        unique case (1'b1)
            (bus.req0_valid & bus.req1_valid): begin
                w_g0 = r_last;
                w_g1 = ~r_last;
            end
            (bus.req0_valid & ~bus.req1_valid): w_g0 = 1'b1;
            (~bus.req0_valid & bus.req1_valid): w_g1 = 1'b1;
            default: ;
        endcase
    end

    assign w_idle = (r_state == S_IDLE) & reset;
    assign w_acc  = w_idle & (w_g0 | w_g1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdy0      = w_idle & w_g0;
        w_rdy1      = w_idle & w_g1;
        w_rsp_valid = (r_state == S_RESP);
    end

    // f[2] turns add into subtract and AND/OR into AND-NOT/OR-NOT
    always_comb begin
        w_bb  = r_f[2] ? ~r_b : r_b;
        w_sum = r_a + w_bb + {31'd0, r_f[2]};
        case (r_f[1:0])
            2'b00: w_y = r_a & w_bb;
            2'b01: w_y = r_a | w_bb;
            2'b10: w_y = w_sum;
            2'b11: w_y = {31'd0, w_sum[31]};
        endcase
        w_ovf = (r_f[1:0] == 2'b10)
              & (r_a[31] == w_bb[31])
              & (w_sum[31] != r_a[31]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last   <= 1'b1;
            r_a      <= '0;
            r_b      <= '0;
            r_f      <= '0;
            r_gid    <= 1'b0;
            r_rsp_id <= 1'b0;
            r_y      <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt0   <= '0;
            r_cnt1   <= '0;
        end else begin
            if (w_acc) begin
                r_last <= w_g1;
                r_gid  <= w_g1;
                r_a    <= w_g1 ? bus.req1_a : bus.req0_a;
                r_b    <= w_g1 ? bus.req1_b : bus.req0_b;
                r_f    <= w_g1 ? bus.req1_f : bus.req0_f;
                if (w_g0 && r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_ONE;
                if (w_g1 && r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_ONE;
            end
            if (r_state == S_EXEC) begin
                r_y      <= w_y;
                r_zero   <= (w_y == 32'd0);
                r_ovf    <= w_ovf;
                r_rsp_id <= r_gid;
            end
        end
    end

    assign bus.req0_ready   = w_rdy0;
    assign bus.req1_ready   = w_rdy1;
    assign bus.rsp_valid    = w_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.rsp_y        = r_y;
    assign bus.rsp_zero     = r_zero;
    assign bus.rsp_overflow = r_ovf;
    assign bus.grant_cnt0   = r_cnt0;
    assign bus.grant_cnt1   = r_cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU vector table plus arbitration,
// back-pressure, mid-flight reset and counter saturation sequences.
module tb_alu_arbiter;

    logic clk;
    logic reset;

    alu_arbiter_if #(.CNT_W(16)) bus ();
    alu_arbiter_if #(.CNT_W(2))  bus2 ();

    alu_arbiter #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    alu_arbiter #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs [13];
    int   n_checks;
    int   n_fail;
    int   m_cnt0;
    int   m_cnt1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input vec_t v);
        if (v.id == 1'b0) begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = v.a;
            bus.req0_b     = v.b;
            bus.req0_f     = v.f;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = v.a;
            bus.req1_b     = v.b;
            bus.req1_f     = v.f;
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("grant_ready", v.id ? bus.req1_ready : bus.req0_ready, 1);
        chk("loser_ready", v.id ? bus.req0_ready : bus.req1_ready, 0);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (v.id == 1'b0) m_cnt0++;
        else              m_cnt1++;
        #1;
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        cyc();
        #1;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_id", bus.rsp_id, v.id);
        chk("rsp_y", bus.rsp_y, v.y);
        chk("rsp_zero", bus.rsp_zero, v.z);
        chk("rsp_overflow", bus.rsp_overflow, v.o);
        chk("grant_cnt0", bus.grant_cnt0, m_cnt0);
        chk("grant_cnt1", bus.grant_cnt1, m_cnt1);
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    initial begin
        int gid  [4];
        int gcyc [4];
        int ng;
        int both;

        n_checks = 0;
        n_fail   = 0;
        m_cnt0   = 0;
        m_cnt1   = 0;

        vecs[0]  = '{1'b0, 32'd5,        32'd3,        3'b010, 32'd8,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h7FFFFFFF, 32'd1,        3'b010, 32'h80000000, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'd5,        32'd5,        3'b110, 32'd0,        1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'd0,        3'b111, 32'd1,        1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h00F000F0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h80000000, 32'd1,        3'b110, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 32'd3,        32'd5,        3'b111, 32'd1,        1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'd5,        32'd3,        3'b111, 32'd0,        1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h80000000, 32'h80000000, 3'b010, 32'd0,        1'b1, 1'b1};
        vecs[11] = '{1'b1, 32'd0,        32'd0,        3'b101, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'd1,        32'hFFFFFFFF, 3'b011, 32'd0,        1'b1, 1'b0};

        reset          = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_f     = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_f     = '0;
        bus.rsp_ready  = 1'b1;
        bus2.req0_valid = 1'b0;
        bus2.req1_valid = 1'b0;
        bus2.req0_a     = 32'd1;
        bus2.req0_b     = 32'd1;
        bus2.req0_f     = 3'b010;
        bus2.req1_a     = '0;
        bus2.req1_b     = '0;
        bus2.req1_f     = '0;
        bus2.rsp_ready  = 1'b1;

        // reset state, with requests pending while reset is low
        @(negedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_y", bus.rsp_y, 0);
        chk("rst_rsp_zero", bus.rsp_zero, 0);
        chk("rst_rsp_ovf", bus.rsp_overflow, 0);
        chk("rst_cnt0", bus.grant_cnt0, 0);
        chk("rst_cnt1", bus.grant_cnt1, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_op(vecs[i]);

        // round-robin with both requesters always valid
        do_reset();
        bus.req0_a     = 32'd1;
        bus.req0_b     = 32'd2;
        bus.req0_f     = 3'b010;
        bus.req1_a     = 32'd3;
        bus.req1_b     = 32'd4;
        bus.req1_f     = 3'b010;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        ng   = 0;
        both = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both++;
            if (bus.req0_ready || bus.req1_ready) begin
                if (ng < 4) begin
                    gid[ng]  = bus.req1_ready ? 1 : 0;
                    gcyc[ng] = c;
                end
                ng++;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("rr_both_ready", both, 0);
        chk("rr_grants", ng, 4);
        chk("rr_first_cycle", gcyc[0], 0);
        for (int i = 0; i < 4; i++) chk("rr_id", gid[i], i % 2);
        for (int i = 1; i < 4; i++) chk("rr_gap", gcyc[i] - gcyc[i-1], 3);
        m_cnt0 = 2;
        m_cnt1 = 2;
        chk("rr_cnt0", bus.grant_cnt0, m_cnt0);
        chk("rr_cnt1", bus.grant_cnt1, m_cnt1);

        // response back-pressure with a second requester pending
        bus.req0_valid = 1'b1;
        bus.req0_a     = 32'd10;
        bus.req0_b     = 32'd4;
        bus.req0_f     = 3'b110;
        bus.rsp_ready  = 1'b0;
        #1;
        chk("bp_ready0", bus.req0_ready, 1);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_a     = 32'd1;
        bus.req1_b     = 32'd2;
        bus.req1_f     = 3'b001;
        m_cnt0++;
        #1;
        chk("bp_exec_ready1", bus.req1_ready, 0);
        cyc();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_y", bus.rsp_y, 6);
            chk("bp_rsp_id", bus.rsp_id, 0);
            chk("bp_ready", {bus.req0_ready, bus.req1_ready}, 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        cyc();
        #1;
        chk("bp_idle_rsp_valid", bus.rsp_valid, 0);
        chk("bp_pending_ready1", bus.req1_ready, 1);
        chk("bp_pending_ready0", bus.req0_ready, 0);
        cyc();
        bus.req1_valid = 1'b0;
        m_cnt1++;
        cyc();
        #1;
        chk("bp2_rsp_valid", bus.rsp_valid, 1);
        chk("bp2_rsp_id", bus.rsp_id, 1);
        chk("bp2_rsp_y", bus.rsp_y, 3);
        chk("bp2_cnt0", bus.grant_cnt0, m_cnt0);
        chk("bp2_cnt1", bus.grant_cnt1, m_cnt1);
        cyc();

        // reset asserted while an operation is in EXEC
        bus.req0_valid = 1'b1;
        bus.req0_a     = 32'd100;
        bus.req0_b     = 32'd1;
        bus.req0_f     = 3'b010;
        cyc();
        bus.req0_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mr_rsp_valid", bus.rsp_valid, 0);
        chk("mr_cnt0", bus.grant_cnt0, 0);
        chk("mr_cnt1", bus.grant_cnt1, 0);
        bus.req0_valid = 1'b1;
        bus.req0_a     = 32'd20;
        bus.req0_b     = 32'd22;
        bus.req0_f     = 3'b010;
        bus.req1_valid = 1'b1;
        #1;
        chk("mr_ready0_in_reset", bus.req0_ready, 0);
        chk("mr_ready1_in_reset", bus.req1_ready, 0);
        @(negedge clk);
        reset  = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        #1;
        chk("mr_post_rsp_valid", bus.rsp_valid, 0);
        chk("mr_post_ready0", bus.req0_ready, 1);
        chk("mr_post_ready1", bus.req1_ready, 0);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        m_cnt0++;
        #1;
        chk("mr_exec_rsp_valid", bus.rsp_valid, 0);
        cyc();
        #1;
        chk("mr_rsp_valid2", bus.rsp_valid, 1);
        chk("mr_rsp_id", bus.rsp_id, 0);
        chk("mr_rsp_y", bus.rsp_y, 42);
        chk("mr_cnt0_after", bus.grant_cnt0, m_cnt0);
        cyc();

        // two-bit counter saturation on the second instance
        for (int n = 1; n <= 5; n++) begin
            bus2.req0_valid = 1'b1;
            cyc();
            bus2.req0_valid = 1'b0;
            cyc();
            cyc();
            #1;
            chk("sat_cnt0", bus2.grant_cnt0, (n > 3) ? 3 : n);
        end
        chk("sat_cnt1", bus2.grant_cnt1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of each per-requester grant counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset asserted when low.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester N operands accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32 each  operands of requester N.
REQ-007 req0_f / req1_f  input  3 each  ALU function code of requester N.
REQ-008 rsp_valid  output  1  result registers hold a valid response.
REQ-009 rsp_id  output  1  requester that owns the response: 0 or 1.
REQ-010 rsp_ready  input  1  owning requester consumes the response.
REQ-011 rsp_y  output  32  result; rsp_zero  output  1  result equals 0; rsp_overflow  output  1  signed overflow.
REQ-012 grant_cnt0 / grant_cnt1  output  CNT_W each  saturating count of accepted operations per requester.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-014 In IDLE, with at least one reqN_valid high, the block SHALL assert exactly one reqN_ready combinationally, latch that requester's a, b and f, and go to EXEC on the next edge.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-016 With a single valid requester, that requester SHALL be granted regardless of the pointer; the pointer SHALL update to the granted requester.
REQ-017 reqN_ready SHALL be low in EXEC and RESP and for the losing requester.
REQ-018 In EXEC, the block SHALL compute from the latched operands, register y, zero, overflow and id, and go to RESP after exactly one cycle.
REQ-019 ALU function: bb = f[2] ? ~b : b; sum = a + bb + f[2] mod 2^32. f[1:0]=00 gives a & bb; 01 gives a | bb; 10 gives sum; 11 gives a zero-extended sum[31] (set-less-than).
REQ-020 zero SHALL be 1 exactly when the 32-bit result is 0.
REQ-021 overflow SHALL be 0 except for f=010 (both operand signs equal and sum sign differs) and f=110 (a sign differs from b sign and sum sign differs from a sign).
REQ-022 In RESP, rsp_valid SHALL be high and all rsp_* outputs SHALL be stable until rsp_ready is high.
REQ-023 With rsp_valid and rsp_ready both high, the block SHALL return to IDLE; a new grant is possible in that next IDLE cycle, giving a minimum of 3 cycles per operation.
REQ-024 Latency from the accept edge to rsp_valid high SHALL be 2 clock edges.
REQ-025 Requester inputs SHALL be ignored outside IDLE; a requester held valid SHALL stay pending with no loss.
REQ-026 grant_cntN SHALL increment on each accept of requester N and saturate at 2^CNT_W-1, with no wrap.
REQ-027 rsp_valid SHALL be low in IDLE and EXEC.

Reset
REQ-028 Reset low SHALL asynchronously force IDLE, clear the round-robin pointer to "last granted = 1", clear the latched operands, and set rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_overflow and both grant counters to 0.
REQ-029 Reset in EXEC or RESP SHALL discard the in-flight operation; no response SHALL be produced after reset is released.
REQ-030 reqN_ready SHALL be low while reset is low.

Verification
REQ-031 req0 only: a=5, b=3, f=010 -> req0_ready pulses once; 2 edges later rsp_valid=1, rsp_id=0, rsp_y=8, zero=0, overflow=0; grant_cnt0=1.
REQ-032 Both valid every cycle after reset, rsp_ready held 1 -> grants alternate 0,1,0,1; each accept is 3 cycles after the previous one; counters are equal after an even number of ops.
REQ-033 req1 a=0x7FFFFFFF, b=1, f=010 -> y=0x80000000, overflow=1; a=5, b=5, f=110 -> y=0, zero=1, overflow=0; a=-1, b=0, f=111 -> y=1.
REQ-034 rsp_ready held low for 10 cycles in RESP -> rsp_* stable, both reqN_ready low; rsp_ready high -> IDLE next cycle, then the pending requester is granted.
REQ-035 Reset pulled low mid-EXEC -> rsp_valid=0 immediately, state IDLE, counters 0; after release with both valid, requester 0 is granted first.
REQ-036 CNT_W=2 with req0 issuing 5 ops -> grant_cnt0 saturates at 3.
